// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
// Pure declarations, no timing or flow-control behaviour of its own.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a selectable reset value, for asynchronous pins.
// Latency 2 cycles; no flow control, samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the start edge.
// Single-entry valid/ready holding register; a byte arriving while it is full is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx: CLK_HZ/BAUD must be at least 8");
  end

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 byte_done;
  logic                 rx_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Bit timing and framing; busy tracks the next state so it is registered with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_done <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must go idle before another start bit can count.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: an accept in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: latency, glitch, framing,
// overrun, accept-during-delivery and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int last_start = 0;
  int rise_cyc = 0;
  int valid_cycles = 0;
  int busy_cycles = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  logic prev_valid = 1'b0;

  uart_rx #(
    .CLK_HZ (1_600_000),
    .BAUD   (100_000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame a cycle at a time; cut>0 abandons it after that many cycles.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int cut);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == 0) last_start = cyc;
      rx = frame[c / CPB];
      @(negedge clk);
      if (cut != 0 && c == cut - 1) break;
    end
  endtask

  // Monitor: sampled just after the falling edge, once stimulus has settled.
  always @(negedge clk) begin
    logic [31:0] exp;
    #1;
    if (rst_n) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (rx_valid) valid_cycles++;
      if (busy) busy_cycles++;
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid && rx_ready) begin
        exp = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'd256;
        chk("sb_rx_data", {24'd0, rx_data}, exp);
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int ovr0;
    int ferr0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with the consumer always ready.
    rx_ready = 1'b1;
    valid_cycles = 0;
    ovr0 = ovr_cnt;
    ferr0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    repeat (10) @(negedge clk);
    // rise_cyc counts the first edge that saw the low line, hence the -1.
    chk("t1_latency", rise_cyc - last_start - 1, 155);
    chk("t1_valid_cycles", valid_cycles, 1);
    chk("t1_ferr", ferr_cnt - ferr0, 0);
    chk("t1_ovr", ovr_cnt - ovr0, 0);

    // Short low glitch must not start a frame.
    valid_cycles = 0;
    busy_cycles = 0;
    ovr0 = ovr_cnt;
    ferr0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_busy_bounded", (busy_cycles > 0 && busy_cycles <= 11), 1);
    chk("t2_valid", valid_cycles, 0);
    chk("t2_ferr", ferr_cnt - ferr0, 0);
    chk("t2_ovr", ovr_cnt - ovr0, 0);

    // Bad stop bit followed by a held break, then a good byte.
    valid_cycles = 0;
    ferr0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0);
    repeat (40) @(negedge clk);
    chk("t3_busy_in_break", busy, 1);
    chk("t3_ferr_pulses", ferr_cnt - ferr0, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_busy_released", busy, 0);
    chk("t3_no_valid", valid_cycles, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0);
    repeat (10) @(negedge clk);
    chk("t3_data_55", rx_data, 8'h55);

    // Back-to-back bytes into a full holding register.
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_valid_held", rx_valid, 1);
    chk("t4_data_held", rx_data, 8'h01);
    chk("t4_overrun", ovr_cnt - ovr0, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("t4_valid_cleared", rx_valid, 0);

    // Accept the old byte in the exact cycle the new one is delivered.
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h10);
    send_frame(8'h10, 1'b1, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h20);
    fork
      send_frame(8'h20, 1'b1, 0);
      begin
        repeat (155) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    rx = 1'b1;
    @(negedge clk);
    chk("t5_valid", rx_valid, 1);
    chk("t5_data_20", rx_data, 8'h20);
    chk("t5_overrun", ovr_cnt - ovr0, 0);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 4.
    send_frame(8'h77, 1'b1, 88);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_ferr", frame_err, 0);
    chk("t6_rst_ovr", overrun, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_data_77", rx_data, 8'h77);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that pairs with the design's serial `tx` output path and closes the loopback for the super-counter example. It synchronizes the asynchronous `rx` pin, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each byte through a valid/ready holding register. Framing errors and overruns are reported as one-cycle pulses.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, line bit rate.
- Derived: CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 8), HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  received byte, stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte dropped because the holding register was full.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert release): state=IDLE, synchronizer flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, bit counter=0, bit index=0.
- Synchronizer: two flops on rx, reset to 1. All logic uses rx_s (2-cycle latency). No other logic touches raw rx.
- IDLE: when rx_s==0, go to START and clear the counter.
- START: at count HALF_BIT-1, sample rx_s.
  - 0 → DATA, counter=0, bit_idx=0.
  - 1 → glitch; return to IDLE with no output activity.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register (shift right, new bit at MSB). After bit_idx==7 is sampled → STOP.
- STOP: sample rx_s at count CLKS_PER_BIT-1.
  - 1 → deliver byte and go to IDLE.
  - 0 → frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A new start bit is never recognised while the line stays low.
- Delivery, in the cycle after a good stop sample:
  - If rx_valid==0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid=1. A simultaneous accept plus new byte gives no gap and no overrun.
  - Otherwise: keep the old rx_data and rx_valid, pulse overrun=1 for one cycle, drop the new byte.
- rx_valid clears on the cycle after an rx_valid & rx_ready handshake, unless a new byte is loaded in that same cycle.
- rx_ready while rx_valid=0 is ignored.
- Counter width: $clog2(CLKS_PER_BIT). The counter never wraps past CLKS_PER_BIT-1.
- Latency: rx_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling edge of the start bit reaches the rx pin.
- Reset asserted mid-frame: immediate return to reset values, and the partial byte is lost. After release the receiver needs the line idle-high before the next start bit, i.e. the IDLE rule with the synchronizer reset to 1.

Decomposition:
- Package uart_pkg: rx state enum (IDLE, START, DATA, STOP, BREAK) and localparam DATA_BITS=8. Shared later with a matching uart_tx.
- One sub-module, sync_2ff: a parameterised reset-value 2-flop synchronizer with async active-low reset. Reused for the button input.
- Counter, FSM and holding register remain inline in uart_rx.

Test Plan:
All tests use CLK_HZ=1_600_000 and BAUD=100_000, giving CLKS_PER_BIT=16 and HALF_BIT=8.
1. Send 0xA5 (8N1), rx_ready=1 → rx_valid pulses for 1 cycle with rx_data=0xA5 exactly 2+8+144+1=155 cycles after the start edge; frame_err=0, overrun=0.
2. Drive rx low for 4 cycles, then high → state returns to IDLE; rx_valid, frame_err and overrun stay 0; busy high for no more than 11 cycles.
3. Send 0x3C with stop bit 0, then hold rx low for 40 cycles → one frame_err pulse, no rx_valid, busy stays high until rx returns high. A following 0x55 is then received correctly.
4. rx_ready=0, send 0x01 then 0xFF back-to-back → rx_valid=1 with rx_data=0x01 held, one overrun pulse at the end of the 0xFF frame. After rx_ready=1 for one cycle, rx_valid=0.
5. rx_ready=0, send 0x10; assert rx_ready exactly in the delivery cycle of a second byte 0x20 → 0x10 is accepted, rx_data=0x20 with rx_valid still 1, overrun=0.
6. Assert rst_n=0 for 3 cycles mid data bit 4 of 0x77 → all outputs are 0 and busy=0 during reset. After release plus idle line, a subsequent 0x77 is received correctly.
